// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Hazard and stall sequencer for the 5-stage RISC-V pipeline.
//                It gates the PC, IF/ID and ID/EX registers for three cases:
//                  - load-use hazard        -> one-cycle bubble into ID/EX
//                  - taken branch in ID     -> flush IF/ID
//                  - data-cache miss        -> freeze the whole pipeline
//                The block also owns the miss-wait FSM with its timeout and
//                two saturating performance counters.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CNT_W        width of the performance counters
//    MISS_TIMEOUT max cycles spent in MISS_WAIT before abort (>= 1)
//  Ports
//    clk_i, rst_i             clock / synchronous active-high reset
//    IDEX_MemRead_i, IDEX_Rd_i  load in ID/EX and its destination
//    IFID_RS1_i, IFID_RS2_i   source registers of the instruction in ID
//    Branch_Taken_i           branch in ID resolved taken
//    EXMEM_MemAccess_i        EX/MEM instruction accesses data memory
//    DCache_Hit_i             data cache hit for the current access
//    DCache_Ack_i             miss refill complete, data valid this cycle
//    PCWrite_o, IFIDWrite_o   PC and IF/ID write enables
//    IDEX_Bubble_o            zero the ID/EX control fields (NOP)
//    IFID_Flush_o             clear IF/ID to NOP
//    Stall_o                  freeze all pipeline registers and PC
//    Err_o                    sticky miss-timeout flag
//    MissCnt_o, BubbleCnt_o   saturating miss / bubble-cycle counters
// ============================================================================
module hazard_stall_ctrl #(
   parameter int CNT_W        = 16,
   parameter int MISS_TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             IDEX_MemRead_i,
   input  logic [4:0]       IDEX_Rd_i,
   input  logic [4:0]       IFID_RS1_i,
   input  logic [4:0]       IFID_RS2_i,
   input  logic             Branch_Taken_i,
   input  logic             EXMEM_MemAccess_i,
   input  logic             DCache_Hit_i,
   input  logic             DCache_Ack_i,
   output logic             PCWrite_o,
   output logic             IFIDWrite_o,
   output logic             IDEX_Bubble_o,
   output logic             IFID_Flush_o,
   output logic             Stall_o,
   output logic             Err_o,
   output logic [CNT_W-1:0] MissCnt_o,
   output logic [CNT_W-1:0] BubbleCnt_o
);

   // Wait counter must be able to hold the value MISS_TIMEOUT itself.
   localparam int c_WCNT_W = (MISS_TIMEOUT < 1) ? 1 : $clog2(MISS_TIMEOUT + 1);
   localparam logic [c_WCNT_W-1:0] c_TIMEOUT  = c_WCNT_W'(MISS_TIMEOUT);
   localparam logic [c_WCNT_W-1:0] c_WCNT_ONE = c_WCNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE      = 1'b0,
      ST_MISS_WAIT = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_stateNext;
   logic [c_WCNT_W-1:0] r_wcnt;
   logic [c_WCNT_W-1:0] w_wcntNext;
   logic                w_errSet;

   logic                w_miss;
   logic                w_waitHold;
   logic                w_loadUse;
   logic                w_missCntSat;
   logic                w_bubbleCntSat;

   // -------------------------------------------------------------------------
   // Hazard detection
   // -------------------------------------------------------------------------
   // A new miss is only recognised from IDLE; while waiting, the hit line
   // belongs to the refill in progress and is ignored.
   assign w_miss = (r_state == ST_IDLE) & EXMEM_MemAccess_i & ~DCache_Hit_i;

   // Keep freezing while the refill is outstanding, but release in the
   // timeout cycle so the pipeline is not held forever by a lost ack.
   assign w_waitHold = (r_state == ST_MISS_WAIT) & ~DCache_Ack_i
                     & (r_wcnt != c_TIMEOUT);

   // x0 is hard-wired zero, so a load targeting it never creates a hazard.
   assign w_loadUse = IDEX_MemRead_i & (IDEX_Rd_i != 5'd0)
                    & ((IDEX_Rd_i == IFID_RS1_i) | (IDEX_Rd_i == IFID_RS2_i));

   assign w_missCntSat   = &MissCnt_o;
   assign w_bubbleCntSat = &BubbleCnt_o;

   // -------------------------------------------------------------------------
   // Pipeline control outputs (combinational, zero latency)
   // Priority: freeze > load-use bubble > branch flush.
   // -------------------------------------------------------------------------
   always_comb begin
      PCWrite_o     = 1'b1;
      IFIDWrite_o   = 1'b1;
      IDEX_Bubble_o = 1'b0;
      IFID_Flush_o  = 1'b0;
      Stall_o       = 1'b0;

      if (rst_i) begin
         // Hold the pipeline in its free-running, inactive state in reset.
         PCWrite_o     = 1'b1;
         IFIDWrite_o   = 1'b1;
      end else if (w_miss | w_waitHold) begin
         // Everything freezes; a pending bubble/flush is simply re-evaluated
         // once the freeze lifts because ID and EX contents are unchanged.
         Stall_o       = 1'b1;
         PCWrite_o     = 1'b0;
         IFIDWrite_o   = 1'b0;
      end else if (w_loadUse) begin
         // Holding IF/ID also holds a dependent branch in ID, so its flush
         // is deferred until the load result can be forwarded.
         PCWrite_o     = 1'b0;
         IFIDWrite_o   = 1'b0;
         IDEX_Bubble_o = 1'b1;
      end else if (Branch_Taken_i) begin
         IFID_Flush_o  = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Miss-wait FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      w_stateNext = r_state;
      w_wcntNext  = r_wcnt;
      w_errSet    = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            // An ack while idle has no refill to complete and is dropped.
            if (w_miss) begin
               w_stateNext = ST_MISS_WAIT;
               w_wcntNext  = c_WCNT_ONE;
            end
         end
         ST_MISS_WAIT: begin
            if (DCache_Ack_i) begin
               // Ack wins over a coincident timeout: the data did arrive.
               w_stateNext = ST_IDLE;
               w_wcntNext  = '0;
            end else if (r_wcnt == c_TIMEOUT) begin
               w_stateNext = ST_IDLE;
               w_wcntNext  = '0;
               w_errSet    = 1'b1;
            end else begin
               w_wcntNext  = r_wcnt + c_WCNT_ONE;
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
            w_wcntNext  = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State, wait counter and sticky error
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_wcnt  <= '0;
         Err_o   <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_wcnt  <= w_wcntNext;
         if (w_errSet) begin
            Err_o <= 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Performance counters: saturate at all-ones, never wrap
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         MissCnt_o <= '0;
      end else if (w_miss && !w_missCntSat) begin
         MissCnt_o <= MissCnt_o + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         BubbleCnt_o <= '0;
      end else if (IDEX_Bubble_o && !w_bubbleCntSat) begin
         BubbleCnt_o <= BubbleCnt_o + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Directed self-checking bench for hazard_stall_ctrl. Two
//                instances share every input: dut (CNT_W=16, timeout 8)
//                and sat (CNT_W=2, timeout 3) for saturation and timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       idexMemRead;
   logic [4:0] idexRd;
   logic [4:0] ifidRs1;
   logic [4:0] ifidRs2;
   logic       branchTaken;
   logic       memAccess;
   logic       hit;
   logic       ack;

   logic        dPcWrite, dIfIdWrite, dBubble, dFlush, dStall, dErr;
   logic [15:0] dMissCnt, dBubbleCnt;
   logic        sPcWrite, sIfIdWrite, sBubble, sFlush, sStall, sErr;
   logic [1:0]  sMissCnt, sBubbleCnt;

   int nTests = 0;
   int nFail  = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.CNT_W(16), .MISS_TIMEOUT(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .IDEX_MemRead_i(idexMemRead), .IDEX_Rd_i(idexRd),
      .IFID_RS1_i(ifidRs1), .IFID_RS2_i(ifidRs2),
      .Branch_Taken_i(branchTaken), .EXMEM_MemAccess_i(memAccess),
      .DCache_Hit_i(hit), .DCache_Ack_i(ack),
      .PCWrite_o(dPcWrite), .IFIDWrite_o(dIfIdWrite),
      .IDEX_Bubble_o(dBubble), .IFID_Flush_o(dFlush),
      .Stall_o(dStall), .Err_o(dErr),
      .MissCnt_o(dMissCnt), .BubbleCnt_o(dBubbleCnt)
   );

   hazard_stall_ctrl #(.CNT_W(2), .MISS_TIMEOUT(3)) sat (
      .clk_i(clk), .rst_i(rst),
      .IDEX_MemRead_i(idexMemRead), .IDEX_Rd_i(idexRd),
      .IFID_RS1_i(ifidRs1), .IFID_RS2_i(ifidRs2),
      .Branch_Taken_i(branchTaken), .EXMEM_MemAccess_i(memAccess),
      .DCache_Hit_i(hit), .DCache_Ack_i(ack),
      .PCWrite_o(sPcWrite), .IFIDWrite_o(sIfIdWrite),
      .IDEX_Bubble_o(sBubble), .IFID_Flush_o(sFlush),
      .Stall_o(sStall), .Err_o(sErr),
      .MissCnt_o(sMissCnt), .BubbleCnt_o(sBubbleCnt)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Move to the next cycle: inputs change 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   task automatic clearInputs();
      idexMemRead = 1'b0; idexRd = 5'd0; ifidRs1 = 5'd0; ifidRs2 = 5'd0;
      branchTaken = 1'b0; memAccess = 1'b0; hit = 1'b0; ack = 1'b0;
   endtask

   task automatic checkCtrl(input string tag, input logic pcw,
                            input logic ifw, input logic bub,
                            input logic fl, input logic st);
      check({tag, ".pcw"},   {31'd0, dPcWrite},   {31'd0, pcw});
      check({tag, ".ifw"},   {31'd0, dIfIdWrite}, {31'd0, ifw});
      check({tag, ".bub"},   {31'd0, dBubble},    {31'd0, bub});
      check({tag, ".flush"}, {31'd0, dFlush},     {31'd0, fl});
      check({tag, ".stall"}, {31'd0, dStall},     {31'd0, st});
   endtask

   initial begin
      clearInputs();
      rst = 1'b1;
      tick();
      // Reset forces controls inactive even with a miss on the inputs.
      memAccess = 1'b1; idexMemRead = 1'b1; idexRd = 5'd4; ifidRs1 = 5'd4;
      settle();
      checkCtrl("rst_ctrl", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("rst_sat_stall", {31'd0, sStall}, 32'd0);
      tick();
      clearInputs();
      rst = 1'b0;
      settle();
      check("rst_misscnt", {16'd0, dMissCnt},   32'd0);
      check("rst_bubcnt",  {16'd0, dBubbleCnt}, 32'd0);
      check("rst_err",     {31'd0, dErr},       32'd0);
      checkCtrl("idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Load-use on RS2.
      idexMemRead = 1'b1; idexRd = 5'd5; ifidRs2 = 5'd5;
      settle();
      checkCtrl("lu_rs2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      clearInputs();
      settle();
      check("lu_bubcnt1", {16'd0, dBubbleCnt}, 32'd1);
      checkCtrl("lu_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Load to x0 never stalls.
      idexMemRead = 1'b1; idexRd = 5'd0; ifidRs1 = 5'd0; ifidRs2 = 5'd0;
      settle();
      checkCtrl("lu_x0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      clearInputs();
      settle();
      check("lu_x0_bubcnt", {16'd0, dBubbleCnt}, 32'd1);

      // Branch together with load-use on RS1: bubble wins, flush deferred.
      idexMemRead = 1'b1; idexRd = 5'd7; ifidRs1 = 5'd7; branchTaken = 1'b1;
      settle();
      checkCtrl("br_lu", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      idexMemRead = 1'b0;
      settle();
      checkCtrl("br_flush", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      clearInputs();
      settle();
      check("br_bubcnt2", {16'd0, dBubbleCnt}, 32'd2);

      // Cache miss at N, ack at N+3 (for sat this is its timeout cycle).
      memAccess = 1'b1; hit = 1'b0;
      settle();
      checkCtrl("miss_n", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("miss_n_cnt", {16'd0, dMissCnt}, 32'd0);
      tick();
      hit = 1'b1;                               // ignored in MISS_WAIT
      settle();
      check("miss_n1_stall", {31'd0, dStall}, 32'd1);
      check("miss_n1_cnt", {16'd0, dMissCnt}, 32'd1);
      tick();
      settle();
      check("miss_n2_stall", {31'd0, dStall}, 32'd1);
      check("miss_n2_sstall", {31'd0, sStall}, 32'd1);
      tick();
      ack = 1'b1;
      settle();
      checkCtrl("miss_ack", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("miss_ack_sstall", {31'd0, sStall}, 32'd0);
      tick();

      // Back-to-back miss with load-use and branch all asserted.
      clearInputs();
      memAccess = 1'b1; hit = 1'b0;
      idexMemRead = 1'b1; idexRd = 5'd3; ifidRs1 = 5'd3; branchTaken = 1'b1;
      settle();
      check("ackts_serr", {31'd0, sErr}, 32'd0);
      check("ackts_derr", {31'd0, dErr}, 32'd0);
      checkCtrl("all3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      settle();
      checkCtrl("all3_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("all3_misscnt", {16'd0, dMissCnt}, 32'd2);
      tick();
      ack = 1'b1;
      settle();
      checkCtrl("all3_ack", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      clearInputs();
      settle();
      check("all3_bubcnt", {16'd0, dBubbleCnt}, 32'd3);
      check("all3_sbubcnt", {30'd0, sBubbleCnt}, 32'd3);
      check("all3_stall", {31'd0, dStall}, 32'd0);

      // Timeout: miss at M, never acked. sat times out at M+3, dut at M+8.
      memAccess = 1'b1; hit = 1'b0;
      settle();
      check("to_m_sstall", {31'd0, sStall}, 32'd1);
      tick();
      clearInputs();
      settle();
      check("to_m1_sstall", {31'd0, sStall}, 32'd1);
      tick();
      settle();
      check("to_m2_sstall", {31'd0, sStall}, 32'd1);
      tick();
      settle();
      check("to_m3_sstall", {31'd0, sStall}, 32'd0);
      check("to_m3_spcw",   {31'd0, sPcWrite}, 32'd1);
      check("to_m3_serr",   {31'd0, sErr}, 32'd0);
      check("to_m3_dstall", {31'd0, dStall}, 32'd1);
      tick();
      settle();
      check("to_m4_serr",   {31'd0, sErr}, 32'd1);
      check("to_m4_sstall", {31'd0, sStall}, 32'd0);
      check("to_m4_dstall", {31'd0, dStall}, 32'd1);
      tick(); tick(); tick();
      settle();
      check("to_m7_dstall", {31'd0, dStall}, 32'd1);
      tick();
      settle();
      check("to_m8_dstall", {31'd0, dStall}, 32'd0);
      check("to_m8_derr",   {31'd0, dErr}, 32'd0);
      tick();
      settle();
      check("to_m9_derr",   {31'd0, dErr}, 32'd1);
      check("to_m9_serr",   {31'd0, sErr}, 32'd1);
      check("to_misscnt",   {16'd0, dMissCnt}, 32'd3);
      check("to_smisscnt",  {30'd0, sMissCnt}, 32'd3);

      // Another miss: sat's miss counter stays saturated.
      memAccess = 1'b1; hit = 1'b0;
      tick();
      clearInputs();
      settle();
      check("sat_misscnt",  {16'd0, dMissCnt}, 32'd4);
      check("sat_smisscnt", {30'd0, sMissCnt}, 32'd3);
      check("sat_err_hold", {31'd0, dErr}, 32'd1);
      check("sat_wait_stall", {31'd0, dStall}, 32'd1);

      // Reset in the middle of MISS_WAIT.
      rst = 1'b1;
      settle();
      check("rstw_stall",  {31'd0, dStall}, 32'd0);
      check("rstw_sstall", {31'd0, sStall}, 32'd0);
      tick();
      rst = 1'b0;
      settle();
      check("rstw_idle",   {31'd0, dStall}, 32'd0);
      check("rstw_sidle",  {31'd0, sStall}, 32'd0);
      check("rstw_misscnt", {16'd0, dMissCnt}, 32'd0);
      check("rstw_bubcnt",  {16'd0, dBubbleCnt}, 32'd0);
      check("rstw_err",     {31'd0, dErr}, 32'd0);
      check("rstw_serr",    {31'd0, sErr}, 32'd0);

      // Five load-use cycles: 2-bit counter saturates at 3.
      idexMemRead = 1'b1; idexRd = 5'd9; ifidRs2 = 5'd9;
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      clearInputs();
      settle();
      check("sat_sbubcnt", {30'd0, sBubbleCnt}, 32'd3);
      check("sat_dbubcnt", {16'd0, dBubbleCnt}, 32'd5);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
`default_nettype wire
